// File: rtl/deinter_sched.sv
// Symbol-level scheduler feeding the OFDM deinterleaver: per-packet config latch,
// one-symbol-at-a-time input gating, drain tracking, completion and stall flags.
module deinter_sched #(
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int SYM_W         = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pkt_start,
    input  logic [7:0]       pkt_rate,
    input  logic [SYM_W-1:0] pkt_num_sym,
    input  logic [5:0]       in_bits,
    input  logic             in_strobe,
    output logic             in_ready,
    output logic             deint_enable,
    output logic             deint_reset,
    output logic [7:0]       deint_rate,
    output logic [5:0]       deint_bits,
    output logic             deint_strobe,
    input  logic             deint_out_strobe,
    output logic             sym_done,
    output logic             pkt_done,
    output logic             busy,
    output logic             err_drop,
    output logic             err_timeout,
    output logic [SYM_W-1:0] sym_count
);
    // state | meaning
    // IDLE  | no packet; deinterleaver held in reset
    // FLUSH | two cycles of deinterleaver reset with the new rate applied
    // LOAD  | accepting N_SC subcarrier words of one symbol
    // DRAIN | demodulator held off until N_DBPS pairs come out
    typedef enum logic [1:0] {IDLE, FLUSH, LOAD, DRAIN} state_t;

    localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_END = TMR_W'(DRAIN_TIMEOUT);

    state_t           state;
    logic [SYM_W-1:0] num_sym_q;
    logic [5:0]       sc_cnt;
    logic [8:0]       pair_cnt;
    logic [TMR_W-1:0] timer;
    logic             flush_cnt;

    logic [5:0]       n_sc;
    logic [8:0]       n_dbps;
    logic [TMR_W-1:0] timer_nxt;
    logic             last_pair;
    logic             last_sym;

    assign n_sc      = deint_rate[7] ? 6'd52 : 6'd48;
    assign timer_nxt = timer + TMR_W'(1);
    assign last_pair = deint_out_strobe && (pair_cnt + 9'd1 == n_dbps);
    assign last_sym  = (sym_count + SYM_W'(1) == num_sym_q);

    always_comb begin
        n_dbps = 9'd24;
        if (deint_rate[7]) begin
            case (deint_rate[3:0])
                4'd0:    n_dbps = 9'd26;
                4'd1:    n_dbps = 9'd52;
                4'd2:    n_dbps = 9'd78;
                4'd3:    n_dbps = 9'd104;
                4'd4:    n_dbps = 9'd156;
                4'd5:    n_dbps = 9'd208;
                4'd6:    n_dbps = 9'd234;
                4'd7:    n_dbps = 9'd260;
                default: n_dbps = 9'd24;
            endcase
        end else begin
            case (deint_rate[3:0])
                4'hB:    n_dbps = 9'd24;
                4'hF:    n_dbps = 9'd36;
                4'hA:    n_dbps = 9'd48;
                4'hE:    n_dbps = 9'd72;
                4'h9:    n_dbps = 9'd96;
                4'hD:    n_dbps = 9'd144;
                4'h8:    n_dbps = 9'd192;
                4'hC:    n_dbps = 9'd216;
                default: n_dbps = 9'd24;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            num_sym_q    <= '0;
            sc_cnt       <= '0;
            pair_cnt     <= '0;
            timer        <= '0;
            flush_cnt    <= 1'b0;
            in_ready     <= 1'b0;
            deint_enable <= 1'b0;
            deint_reset  <= 1'b1;
            deint_rate   <= '0;
            deint_bits   <= '0;
            deint_strobe <= 1'b0;
            sym_done     <= 1'b0;
            pkt_done     <= 1'b0;
            busy         <= 1'b0;
            err_drop     <= 1'b0;
            err_timeout  <= 1'b0;
            sym_count    <= '0;
        end else begin
            deint_strobe <= 1'b0;
            sym_done     <= 1'b0;
            pkt_done     <= 1'b0;
            if (in_strobe && !in_ready)
                err_drop <= 1'b1;

            if (pkt_start) begin
                // A packet finishing on this very cycle still reports completion.
                if (state == DRAIN && last_pair && last_sym) begin
                    sym_done <= 1'b1;
                    pkt_done <= 1'b1;
                end
                deint_rate   <= pkt_rate;
                num_sym_q    <= pkt_num_sym;
                sym_count    <= '0;
                err_drop     <= 1'b0;
                err_timeout  <= 1'b0;
                sc_cnt       <= '0;
                pair_cnt     <= '0;
                timer        <= '0;
                flush_cnt    <= 1'b0;
                in_ready     <= 1'b0;
                deint_enable <= 1'b0;
                deint_reset  <= 1'b1;
                if (pkt_num_sym == '0) begin
                    pkt_done <= 1'b1;
                    state    <= IDLE;
                    busy     <= 1'b0;
                end else begin
                    state <= FLUSH;
                    busy  <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: ;
                    FLUSH: begin
                        if (flush_cnt) begin
                            state        <= LOAD;
                            deint_reset  <= 1'b0;
                            deint_enable <= 1'b1;
                            in_ready     <= 1'b1;
                        end else begin
                            flush_cnt <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (in_strobe && in_ready) begin
                            deint_strobe <= 1'b1;
                            deint_bits   <= in_bits;
                            if (sc_cnt == n_sc - 6'd1) begin
                                sc_cnt   <= '0;
                                timer    <= '0;
                                in_ready <= 1'b0;
                                state    <= DRAIN;
                            end else begin
                                sc_cnt <= sc_cnt + 6'd1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (deint_out_strobe) begin
                            timer <= '0;
                            if (last_pair) begin
                                pair_cnt  <= '0;
                                sym_done  <= 1'b1;
                                sym_count <= sym_count + SYM_W'(1);
                                if (last_sym) begin
                                    pkt_done     <= 1'b1;
                                    state        <= IDLE;
                                    busy         <= 1'b0;
                                    deint_enable <= 1'b0;
                                    deint_reset  <= 1'b1;
                                end else begin
                                    state    <= LOAD;
                                    in_ready <= 1'b1;
                                end
                            end else begin
                                pair_cnt <= pair_cnt + 9'd1;
                            end
                        end else if (timer_nxt == TMR_END) begin
                            err_timeout  <= 1'b1;
                            state        <= IDLE;
                            busy         <= 1'b0;
                            deint_enable <= 1'b0;
                            deint_reset  <= 1'b1;
                            timer        <= '0;
                            pair_cnt     <= '0;
                        end else begin
                            timer <= timer_nxt;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_deinter_sched.sv
// Scoreboard bench for deinter_sched: stimulus pushes expected output events,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_deinter_sched;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pkt_start = 1'b0;
    logic [7:0]  pkt_rate = '0;
    logic [15:0] pkt_num_sym = '0;
    logic [5:0]  in_bits = '0;
    logic        in_strobe = 1'b0;
    logic        in_ready;
    logic        deint_enable;
    logic        deint_reset;
    logic [7:0]  deint_rate;
    logic [5:0]  deint_bits;
    logic        deint_strobe;
    logic        deint_out_strobe = 1'b0;
    logic        sym_done;
    logic        pkt_done;
    logic        busy;
    logic        err_drop;
    logic        err_timeout;
    logic [15:0] sym_count;

    deinter_sched #(.DRAIN_TIMEOUT(1024), .SYM_W(16)) dut (
        .clock(clock), .reset(reset), .pkt_start(pkt_start), .pkt_rate(pkt_rate),
        .pkt_num_sym(pkt_num_sym), .in_bits(in_bits), .in_strobe(in_strobe),
        .in_ready(in_ready), .deint_enable(deint_enable), .deint_reset(deint_reset),
        .deint_rate(deint_rate), .deint_bits(deint_bits), .deint_strobe(deint_strobe),
        .deint_out_strobe(deint_out_strobe), .sym_done(sym_done), .pkt_done(pkt_done),
        .busy(busy), .err_drop(err_drop), .err_timeout(err_timeout), .sym_count(sym_count)
    );

    always #5 clock = ~clock;

    localparam int K_STRB = 0;
    localparam int K_SYM  = 1;
    localparam int K_PKT  = 2;

    typedef struct {
        int kind;
        int val;   // -1: value not checked
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic push(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pop_check(input int kind, input int val, input string name);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: unexpected event with value %0d, expected none", name, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (e.val >= 0 && e.val != val)) begin
                n_bad++;
                $display("FAIL %s: got kind %0d value %0d, expected kind %0d value %0d",
                         name, kind, val, e.kind, e.val);
            end
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (deint_strobe) pop_check(K_STRB, int'(deint_bits), "deint_bits");
            if (sym_done)     pop_check(K_SYM, int'(sym_count), "sym_done");
            if (pkt_done)     pop_check(K_PKT, int'(sym_count), "pkt_done");
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_pkt(input logic [7:0] rate, input logic [15:0] nsym);
        pkt_start   = 1'b1;
        pkt_rate    = rate;
        pkt_num_sym = nsym;
        tick();
        pkt_start = 1'b0;
        check("flush1_deint_reset", deint_reset, 1);
        check("flush1_busy", busy, 1);
        check("flush1_rate", deint_rate, rate);
        check("start_err_drop", err_drop, 0);
        check("start_err_timeout", err_timeout, 0);
        check("start_sym_count", sym_count, 0);
        tick();
        check("flush2_deint_reset", deint_reset, 1);
        check("flush2_in_ready", in_ready, 0);
        tick();
        check("load_in_ready", in_ready, 1);
        check("load_deint_reset", deint_reset, 0);
        check("load_deint_enable", deint_enable, 1);
    endtask

    task automatic load_symbol(input int n_sc, input int seed);
        for (int i = 0; i < n_sc; i++) begin
            if (i == n_sc - 1) check("in_ready_last_word", in_ready, 1);
            in_strobe = 1'b1;
            in_bits   = 6'((i * 5 + seed) & 63);
            push(K_STRB, (i * 5 + seed) & 63);
            tick();
        end
        in_strobe = 1'b0;
        check("in_ready_after_symbol", in_ready, 0);
    endtask

    task automatic drain_symbol(input int n_dbps, input int exp_cnt, input bit last,
                                input bit restart);
        for (int i = 0; i < n_dbps; i++) begin
            deint_out_strobe = 1'b1;
            if (i == n_dbps - 1) begin
                push(K_SYM, restart ? -1 : exp_cnt);
                if (last) push(K_PKT, restart ? -1 : exp_cnt);
                if (restart) begin
                    pkt_start   = 1'b1;
                    pkt_rate    = 8'h0B;
                    pkt_num_sym = 16'd1;
                end
            end
            tick();
        end
        deint_out_strobe = 1'b0;
        pkt_start        = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_deint_reset", deint_reset, 1);
        check("rst_deint_enable", deint_enable, 0);
        check("rst_deint_strobe", deint_strobe, 0);
        check("rst_deint_rate", deint_rate, 0);
        check("rst_busy", busy, 0);
        check("rst_sym_count", sym_count, 0);
        check("rst_err_drop", err_drop, 0);
        check("rst_err_timeout", err_timeout, 0);
        reset = 1'b0;
        tick();

        // Legacy 6M, two symbols: 48 in / 24 pairs each.
        start_pkt(8'h0B, 16'd2);
        load_symbol(48, 3);
        drain_symbol(24, 1, 1'b0, 1'b0);
        check("mid_pkt_in_ready", in_ready, 1);
        load_symbol(48, 11);
        drain_symbol(24, 2, 1'b1, 1'b0);
        check("leg_sym_count", sym_count, 2);
        check("leg_busy_after", busy, 0);
        check("leg_deint_reset_after", deint_reset, 1);

        // HT MCS7: 52 in / 260 pairs, plus a word offered during DRAIN.
        start_pkt(8'h87, 16'd1);
        load_symbol(52, 7);
        in_strobe = 1'b1;
        in_bits   = 6'h2A;
        tick();
        in_strobe = 1'b0;
        check("drain_err_drop", err_drop, 1);
        drain_symbol(260, 1, 1'b1, 1'b0);
        check("ht_sym_count", sym_count, 1);
        check("ht_err_drop_sticky", err_drop, 1);

        // DRAIN stall: timeout after exactly 1024 idle cycles.
        start_pkt(8'h0B, 16'd1);
        load_symbol(48, 20);
        repeat (1023) tick();
        check("pre_timeout_err", err_timeout, 0);
        check("pre_timeout_busy", busy, 1);
        tick();
        check("timeout_err", err_timeout, 1);
        check("timeout_busy", busy, 0);
        check("timeout_deint_reset", deint_reset, 1);
        check("timeout_deint_enable", deint_enable, 0);

        // Abort mid-LOAD with a new rate; the new packet counts 48 afresh.
        start_pkt(8'h0B, 16'd1);
        for (int i = 0; i < 20; i++) begin
            in_strobe = 1'b1;
            in_bits   = 6'(i);
            push(K_STRB, i);
            tick();
        end
        in_strobe = 1'b0;
        start_pkt(8'h0C, 16'd1);
        load_symbol(48, 9);
        drain_symbol(216, 1, 1'b1, 1'b0);
        check("abort_sym_count", sym_count, 1);

        // Zero-symbol packet.
        pkt_start   = 1'b1;
        pkt_rate    = 8'h0B;
        pkt_num_sym = 16'd0;
        push(K_PKT, 0);
        tick();
        pkt_start = 1'b0;
        check("zero_busy1", busy, 0);
        check("zero_deint_reset", deint_reset, 1);
        tick();
        check("zero_busy2", busy, 0);

        // New pkt_start on the final pair: completion reported, new packet flushes.
        start_pkt(8'h0A, 16'd1);
        load_symbol(48, 1);
        drain_symbol(48, 1, 1'b1, 1'b1);
        check("restart_busy", busy, 1);
        check("restart_rate", deint_rate, 8'h0B);
        check("restart_sym_count", sym_count, 0);
        check("restart_deint_reset", deint_reset, 1);
        tick();
        tick();
        check("restart_in_ready", in_ready, 1);

        // Async reset mid-LOAD.
        for (int i = 0; i < 5; i++) begin
            in_strobe = 1'b1;
            in_bits   = 6'(40 + i);
            push(K_STRB, 40 + i);
            tick();
        end
        in_strobe = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 0);
        check("arst_busy", busy, 0);
        check("arst_deint_reset", deint_reset, 1);
        check("arst_deint_rate", deint_rate, 0);
        check("arst_deint_strobe", deint_strobe, 0);
        check("arst_sym_count", sym_count, 0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        check("arst_no_pulse", int'(sym_done | pkt_done | deint_strobe), 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
